// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_pkg
// Description : Shared widths, raster mode record and standard mode presets
//               for the reconfigurable video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    // Default counter / configuration field width.
    localparam int CNT_W_DEF = 12;

    // One axis of a raster mode: active, front porch, sync, back porch, polarity.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] act;
        logic [CNT_W_DEF-1:0] fp;
        logic [CNT_W_DEF-1:0] sync;
        logic [CNT_W_DEF-1:0] bp;
        logic                 pol;
    } axis_mode_t;

    // Complete raster mode (horizontal and vertical axes).
    typedef struct packed {
        axis_mode_t h;
        axis_mode_t v;
    } mode_t;

    // SVGA 800x600 @ 60 Hz, positive syncs (reset-default mode).
    localparam mode_t MODE_800x600_60 = '{
        h: '{act: 12'd800, fp: 12'd40, sync: 12'd128, bp: 12'd88, pol: 1'b1},
        v: '{act: 12'd600, fp: 12'd1,  sync: 12'd4,   bp: 12'd23, pol: 1'b1}
    };

    // VGA 640x480 @ 60 Hz, negative syncs.
    localparam mode_t MODE_640x480_60 = '{
        h: '{act: 12'd640, fp: 12'd16, sync: 12'd96, bp: 12'd48, pol: 1'b0},
        v: '{act: 12'd480, fp: 12'd10, sync: 12'd2,  bp: 12'd33, pol: 1'b0}
    };

endpackage
`default_nettype wire

// File: rtl/video_axis_timer.sv
`default_nettype none
// ============================================================================
// Module      : video_axis_timer
// Description : One raster axis: position counter with wrap, plus registered
//               sync / blank decode of the position being entered.
// Revision    : 1.0 - initial release
// ============================================================================
module video_axis_timer #(
    parameter int   CNT_W    = 12,
    parameter int   RST_LAST = 0,
    parameter logic RST_POL  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             step_i,
    input  logic [CNT_W-1:0] last_i,
    input  logic [CNT_W-1:0] dec_act_i,
    input  logic [CNT_W-1:0] dec_fp_i,
    input  logic [CNT_W-1:0] dec_sync_i,
    input  logic             dec_pol_i,
    output logic [CNT_W-1:0] pos_o,
    output logic             at_last_o,
    output logic             active_nxt_o,
    output logic             sync_o,
    output logic             blank_o
);

    logic [CNT_W-1:0] pos_q, pos_d;
    logic             sync_q, sync_d;
    logic             blank_q, blank_d;
    logic [CNT_W:0]   w_sync_beg, w_sync_end;
    logic             w_in_sync;

    // The wrap point always comes from the configuration of the running frame.
    assign at_last_o = (pos_q == last_i);

    // Sync window bounds, one bit wider so act+fp+sync cannot alias.
    assign w_sync_beg = {1'b0, dec_act_i} + {1'b0, dec_fp_i};
    assign w_sync_end = w_sync_beg + {1'b0, dec_sync_i};

    // Next position and the decode of that position, so outputs line up with it.
    always_comb begin
        pos_d = pos_q;
        if (step_i) begin
            pos_d = at_last_o ? '0 : pos_q + 1'b1;
        end
        w_in_sync    = ({1'b0, pos_d} >= w_sync_beg) && ({1'b0, pos_d} < w_sync_end);
        sync_d       = w_in_sync ? dec_pol_i : ~dec_pol_i;
        active_nxt_o = (pos_d < dec_act_i);
        blank_d      = ~active_nxt_o;
    end

    // Position and decoded outputs only move when the axis steps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q   <= CNT_W'(RST_LAST);
            sync_q  <= ~RST_POL;
            blank_q <= 1'b1;
        end else if (step_i) begin
            pos_q   <= pos_d;
            sync_q  <= sync_d;
            blank_q <= blank_d;
        end
    end

    assign pos_o   = pos_q;
    assign sync_o  = sync_q;
    assign blank_o = blank_q;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen_cfg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_cfg
// Description : Runtime-reconfigurable raster timing generator. New modes are
//               validated, held pending and switched in on a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen_cfg
    import video_timing_pkg::*;
#(
    parameter int   CNT_W  = CNT_W_DEF,
    parameter int   H_ACT  = int'(MODE_800x600_60.h.act),
    parameter int   H_FP   = int'(MODE_800x600_60.h.fp),
    parameter int   H_SYNC = int'(MODE_800x600_60.h.sync),
    parameter int   H_BP   = int'(MODE_800x600_60.h.bp),
    parameter int   V_ACT  = int'(MODE_800x600_60.v.act),
    parameter int   V_FP   = int'(MODE_800x600_60.v.fp),
    parameter int   V_SYNC = int'(MODE_800x600_60.v.sync),
    parameter int   V_BP   = int'(MODE_800x600_60.v.bp),
    parameter logic H_POL  = MODE_800x600_60.h.pol,
    parameter logic V_POL  = MODE_800x600_60.v.pol
) (
    input  logic             pixel_clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cfg_h_act_i,
    input  logic [CNT_W-1:0] cfg_h_fp_i,
    input  logic [CNT_W-1:0] cfg_h_sync_i,
    input  logic [CNT_W-1:0] cfg_h_bp_i,
    input  logic [CNT_W-1:0] cfg_v_act_i,
    input  logic [CNT_W-1:0] cfg_v_fp_i,
    input  logic [CNT_W-1:0] cfg_v_sync_i,
    input  logic [CNT_W-1:0] cfg_v_bp_i,
    input  logic             cfg_h_pol_i,
    input  logic             cfg_v_pol_i,
    input  logic             cfg_load_i,
    output logic             cfg_pending_o,
    output logic             cfg_err_o,
    output logic             h_sync_o,
    output logic             v_sync_o,
    output logic             de_o,
    output logic             hblank_o,
    output logic             vblank_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic [CNT_W-1:0] h_pos_o,
    output logic [CNT_W-1:0] v_pos_o
);

    typedef struct packed {
        logic [CNT_W-1:0] act;
        logic [CNT_W-1:0] fp;
        logic [CNT_W-1:0] sync;
        logic [CNT_W-1:0] bp;
        logic             pol;
    } axis_cfg_t;

    localparam axis_cfg_t C_RST_H = '{act: CNT_W'(H_ACT), fp: CNT_W'(H_FP),
                                      sync: CNT_W'(H_SYNC), bp: CNT_W'(H_BP), pol: H_POL};
    localparam axis_cfg_t C_RST_V = '{act: CNT_W'(V_ACT), fp: CNT_W'(V_FP),
                                      sync: CNT_W'(V_SYNC), bp: CNT_W'(V_BP), pol: V_POL};
    localparam int C_H_LAST = H_ACT + H_FP + H_SYNC + H_BP - 1;
    localparam int C_V_LAST = V_ACT + V_FP + V_SYNC + V_BP - 1;

    // Accept an axis only with non-zero active and sync and a total that fits
    // the counter. Two guard bits keep the four-term sum from wrapping.
    function automatic logic axis_ok(axis_cfg_t c);
        logic [CNT_W+1:0] tot;
        tot = {2'b00, c.act} + {2'b00, c.fp} + {2'b00, c.sync} + {2'b00, c.bp};
        return (c.act != '0) && (c.sync != '0) && (tot <= {2'b00, {CNT_W{1'b1}}});
    endfunction

    // Last counter value of an axis (total - 1); only used on validated configs.
    function automatic logic [CNT_W-1:0] axis_last(axis_cfg_t c);
        return c.act + c.fp + c.sync + c.bp - 1'b1;
    endfunction

    axis_cfg_t        cur_h_q, cur_v_q;
    axis_cfg_t        pnd_h_q, pnd_v_q;
    axis_cfg_t        w_req_h, w_req_v;
    axis_cfg_t        w_dec_h, w_dec_v;
    logic             pending_q, pending_d;
    logic             err_q;
    logic             de_q;
    logic             line_start_q;
    logic             frame_start_q;
    logic [CNT_W-1:0] w_h_last, w_v_last;
    logic             w_load_ok;
    logic             w_h_at_last, w_v_at_last;
    logic             w_boundary, w_apply;
    logic             w_h_act_nxt, w_v_act_nxt;
    logic             w_v_step;

    assign w_req_h = '{act: cfg_h_act_i, fp: cfg_h_fp_i, sync: cfg_h_sync_i,
                       bp: cfg_h_bp_i, pol: cfg_h_pol_i};
    assign w_req_v = '{act: cfg_v_act_i, fp: cfg_v_fp_i, sync: cfg_v_sync_i,
                       bp: cfg_v_bp_i, pol: cfg_v_pol_i};

    assign w_load_ok  = cfg_load_i && axis_ok(w_req_h) && axis_ok(w_req_v);
    assign w_h_last   = axis_last(cur_h_q);
    assign w_v_last   = axis_last(cur_v_q);
    assign w_boundary = en_i && w_h_at_last && w_v_at_last;
    assign w_apply    = w_boundary && pending_q;
    assign w_v_step   = en_i && w_h_at_last;

    // Pixel (0,0) of a switched frame is decoded with the incoming mode.
    assign w_dec_h = w_apply ? pnd_h_q : cur_h_q;
    assign w_dec_v = w_apply ? pnd_v_q : cur_v_q;

    // A load in the boundary cycle re-arms pending for the following frame.
    always_comb begin
        pending_d = pending_q;
        if (w_load_ok) begin
            pending_d = 1'b1;
        end else if (w_apply) begin
            pending_d = 1'b0;
        end
    end

    // Configuration registers, error pulse, data-enable and strobes.
    always_ff @(posedge pixel_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cur_h_q       <= C_RST_H;
            cur_v_q       <= C_RST_V;
            pnd_h_q       <= '0;
            pnd_v_q       <= '0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (w_load_ok) begin
                pnd_h_q <= w_req_h;
                pnd_v_q <= w_req_v;
            end
            if (w_apply) begin
                cur_h_q <= pnd_h_q;
                cur_v_q <= pnd_v_q;
            end
            pending_q     <= pending_d;
            err_q         <= cfg_load_i && !w_load_ok;
            line_start_q  <= w_v_step;
            frame_start_q <= w_boundary;
            if (en_i) begin
                de_q <= w_h_act_nxt && w_v_act_nxt;
            end
        end
    end

    video_axis_timer #(
        .CNT_W    (CNT_W),
        .RST_LAST (C_H_LAST),
        .RST_POL  (H_POL)
    ) u_h_axis (
        .clk_i        (pixel_clk_i),
        .rst_ni       (reset_ni),
        .step_i       (en_i),
        .last_i       (w_h_last),
        .dec_act_i    (w_dec_h.act),
        .dec_fp_i     (w_dec_h.fp),
        .dec_sync_i   (w_dec_h.sync),
        .dec_pol_i    (w_dec_h.pol),
        .pos_o        (h_pos_o),
        .at_last_o    (w_h_at_last),
        .active_nxt_o (w_h_act_nxt),
        .sync_o       (h_sync_o),
        .blank_o      (hblank_o)
    );

    video_axis_timer #(
        .CNT_W    (CNT_W),
        .RST_LAST (C_V_LAST),
        .RST_POL  (V_POL)
    ) u_v_axis (
        .clk_i        (pixel_clk_i),
        .rst_ni       (reset_ni),
        .step_i       (w_v_step),
        .last_i       (w_v_last),
        .dec_act_i    (w_dec_v.act),
        .dec_fp_i     (w_dec_v.fp),
        .dec_sync_i   (w_dec_v.sync),
        .dec_pol_i    (w_dec_v.pol),
        .pos_o        (v_pos_o),
        .at_last_o    (w_v_at_last),
        .active_nxt_o (w_v_act_nxt),
        .sync_o       (v_sync_o),
        .blank_o      (vblank_o)
    );

    assign cfg_pending_o = pending_q;
    assign cfg_err_o     = err_q;
    assign de_o          = de_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen_cfg
// Description : Directed bench for video_timing_gen_cfg with a behavioural
//               raster model feeding an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen_cfg;

    localparam int W = 12;

    typedef struct packed {
        logic [W-1:0] ha, hf, hs, hb, va, vf, vs, vb;
        logic         hp, vp;
    } cfg_t;

    typedef struct packed {
        logic [W-1:0] hpos, vpos;
        logic hsync, vsync, de, hblank, vblank, ls, fs, pend, err;
    } obs_t;

    // Small reset-default mode D of the main instance: h 10/2/2/2 (16), v 5/1/1/1 (8).
    localparam cfg_t MODE_D  = '{ha: 12'd10, hf: 12'd2, hs: 12'd2, hb: 12'd2,
                                 va: 12'd5,  vf: 12'd1, vs: 12'd1, vb: 12'd1, hp: 1'b1, vp: 1'b0};
    localparam cfg_t MODE_S  = '{ha: 12'd8, hf: 12'd2, hs: 12'd3, hb: 12'd1,
                                 va: 12'd4, vf: 12'd1, vs: 12'd2, vb: 12'd1, hp: 1'b1, vp: 1'b1};
    localparam cfg_t MODE_S0 = '{ha: 12'd8, hf: 12'd2, hs: 12'd3, hb: 12'd1,
                                 va: 12'd4, vf: 12'd1, vs: 12'd2, vb: 12'd1, hp: 1'b0, vp: 1'b0};
    localparam cfg_t MODE_Z  = '{ha: 12'd6, hf: 12'd0, hs: 12'd2, hb: 12'd0,
                                 va: 12'd3, vf: 12'd0, vs: 12'd1, vb: 12'd0, hp: 1'b1, vp: 1'b1};
    localparam obs_t RST_OBS = '{hpos: 12'd15, vpos: 12'd7, hsync: 1'b0, vsync: 1'b1, de: 1'b0,
                                 hblank: 1'b1, vblank: 1'b1, ls: 1'b0, fs: 1'b0, pend: 1'b0, err: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main (small-default) instance
    logic rst_n, en, load;
    cfg_t req;
    logic [W-1:0] d_hpos, d_vpos;
    logic d_hs, d_vs, d_de, d_hb, d_vb, d_ls, d_fs, d_pend, d_err;

    // Instance with the full 800x600 defaults
    logic rst_def_n, en_def, load_def;
    cfg_t req_def;
    logic [W-1:0] z_hpos, z_vpos;
    logic z_hs, z_vs, z_de, z_hb, z_vb, z_ls, z_fs, z_pend, z_err;

    video_timing_gen_cfg #(
        .CNT_W(W), .H_ACT(10), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACT(5), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0)
    ) u_dut (
        .pixel_clk_i(clk), .reset_ni(rst_n), .en_i(en),
        .cfg_h_act_i(req.ha), .cfg_h_fp_i(req.hf), .cfg_h_sync_i(req.hs), .cfg_h_bp_i(req.hb),
        .cfg_v_act_i(req.va), .cfg_v_fp_i(req.vf), .cfg_v_sync_i(req.vs), .cfg_v_bp_i(req.vb),
        .cfg_h_pol_i(req.hp), .cfg_v_pol_i(req.vp), .cfg_load_i(load),
        .cfg_pending_o(d_pend), .cfg_err_o(d_err), .h_sync_o(d_hs), .v_sync_o(d_vs),
        .de_o(d_de), .hblank_o(d_hb), .vblank_o(d_vb), .line_start_o(d_ls),
        .frame_start_o(d_fs), .h_pos_o(d_hpos), .v_pos_o(d_vpos)
    );

    video_timing_gen_cfg u_dut_def (
        .pixel_clk_i(clk), .reset_ni(rst_def_n), .en_i(en_def),
        .cfg_h_act_i(req_def.ha), .cfg_h_fp_i(req_def.hf), .cfg_h_sync_i(req_def.hs), .cfg_h_bp_i(req_def.hb),
        .cfg_v_act_i(req_def.va), .cfg_v_fp_i(req_def.vf), .cfg_v_sync_i(req_def.vs), .cfg_v_bp_i(req_def.vb),
        .cfg_h_pol_i(req_def.hp), .cfg_v_pol_i(req_def.vp), .cfg_load_i(load_def),
        .cfg_pending_o(z_pend), .cfg_err_o(z_err), .h_sync_o(z_hs), .v_sync_o(z_vs),
        .de_o(z_de), .hblank_o(z_hb), .vblank_o(z_vb), .line_start_o(z_ls),
        .frame_start_o(z_fs), .h_pos_o(z_hpos), .v_pos_o(z_vpos)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Behavioural raster model of the main instance
    cfg_t m_cur, m_pnd;
    bit   m_pend;
    int   m_h, m_v;
    obs_t m_out;

    function automatic int tot_h(cfg_t c);
        return int'(c.ha) + int'(c.hf) + int'(c.hs) + int'(c.hb);
    endfunction

    function automatic int tot_v(cfg_t c);
        return int'(c.va) + int'(c.vf) + int'(c.vs) + int'(c.vb);
    endfunction

    function automatic bit cfg_valid(cfg_t c);
        return (c.ha != 0) && (c.hs != 0) && (c.va != 0) && (c.vs != 0) &&
               (tot_h(c) < 4096) && (tot_v(c) < 4096);
    endfunction

    function automatic logic sync_at(int p, int a, int f, int s, logic pol);
        return (p >= a + f && p < a + f + s) ? pol : ~pol;
    endfunction

    function automatic obs_t dut_obs();
        return '{hpos: d_hpos, vpos: d_vpos, hsync: d_hs, vsync: d_vs, de: d_de, hblank: d_hb,
                 vblank: d_vb, ls: d_ls, fs: d_fs, pend: d_pend, err: d_err};
    endfunction

    function automatic obs_t def_obs();
        return '{hpos: z_hpos, vpos: z_vpos, hsync: z_hs, vsync: z_vs, de: z_de, hblank: z_hb,
                 vblank: z_vb, ls: z_ls, fs: z_fs, pend: z_pend, err: z_err};
    endfunction

    task automatic model_reset();
        m_cur  = MODE_D;
        m_pnd  = '0;
        m_pend = 1'b0;
        m_h    = 15;
        m_v    = 7;
        m_out  = RST_OBS;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_clock(bit e, bit ld, cfg_t r);
        bit hl, vl, bnd, apply, ok;
        hl    = (m_h == tot_h(m_cur) - 1);
        vl    = (m_v == tot_v(m_cur) - 1);
        bnd   = e && hl && vl;
        apply = bnd && m_pend;
        ok    = cfg_valid(r);
        if (e) begin
            if (hl) begin
                m_h = 0;
                m_v = vl ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        if (apply) m_cur = m_pnd;
        if (ld && ok) begin
            m_pnd  = r;
            m_pend = 1'b1;
        end else if (apply) begin
            m_pend = 1'b0;
        end
        m_out.err  = ld && !ok;
        m_out.ls   = e && hl;
        m_out.fs   = bnd;
        m_out.pend = m_pend;
        if (e) begin
            m_out.hpos   = W'(m_h);
            m_out.vpos   = W'(m_v);
            m_out.hsync  = sync_at(m_h, int'(m_cur.ha), int'(m_cur.hf), int'(m_cur.hs), m_cur.hp);
            m_out.vsync  = sync_at(m_v, int'(m_cur.va), int'(m_cur.vf), int'(m_cur.vs), m_cur.vp);
            m_out.de     = (m_h < int'(m_cur.ha)) && (m_v < int'(m_cur.va));
            m_out.hblank = (m_h >= int'(m_cur.ha));
            m_out.vblank = (m_v >= int'(m_cur.va));
        end
    endtask

    task automatic check(string tag, obs_t got, obs_t want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic check_bit(string tag, logic got, logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic check_int(string tag, int got, int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // One clock: drive on the falling edge, queue the model's prediction,
    // compare just after the rising edge.
    task automatic cyc(bit e, bit ld, cfg_t r);
        obs_t want;
        @(negedge clk);
        en   = e;
        load = ld;
        req  = r;
        model_clock(e, ld, r);
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check("cyc", dut_obs(), want);
    endtask

    // Clock until frame_start is seen (bounded); n is the clock count.
    task automatic run_until_fs(int bound, bit toggle, output int n);
        n = 0;
        do begin
            cyc(toggle ? (n % 2 == 1) : 1'b1, 1'b0, req);
            n++;
        end while (!d_fs && n < bound);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   k;
        int   hp;
        int   vp;
        obs_t e_def;
        cfg_t bad;

        rst_n = 1'b0; en = 1'b0; load = 1'b0; req = MODE_D;
        rst_def_n = 1'b0; en_def = 1'b0; load_def = 1'b0; req_def = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset values of both instances
        check("def_reset", def_obs(), '{hpos: 12'd1055, vpos: 12'd627, hsync: 1'b0, vsync: 1'b0,
              de: 1'b0, hblank: 1'b1, vblank: 1'b1, ls: 1'b0, fs: 1'b0, pend: 1'b0, err: 1'b0});
        check("small_reset", dut_obs(), RST_OBS);

        // 800x600 defaults: first line and start of second
        @(negedge clk);
        rst_def_n = 1'b1;
        en_def    = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk);
            #1;
            hp = i % 1056;
            vp = i / 1056;
            e_def = '{hpos: W'(hp), vpos: W'(vp), hsync: (hp >= 840 && hp < 968), vsync: 1'b0,
                      de: (hp < 800), hblank: (hp >= 800), vblank: 1'b0, ls: (hp == 0),
                      fs: (i == 0), pend: 1'b0, err: 1'b0};
            check("def_line", def_obs(), e_def);
        end
        en_def = 1'b0;

        // Main instance: start and one period in mode D
        @(negedge clk);
        rst_n = 1'b1;
        run_until_fs(300, 1'b0, n);
        check_int("d_first_fs", n, 1);
        run_until_fs(300, 1'b0, n);
        check_int("d_period", n, 128);

        // Load S mid-frame; takes effect only at the boundary
        repeat (20) cyc(1'b1, 1'b0, MODE_D);
        cyc(1'b1, 1'b1, MODE_S);
        check_bit("pend_set", d_pend, 1'b1);
        run_until_fs(300, 1'b0, n);
        check_int("s_switch", n, 107);
        check_bit("pend_clr", d_pend, 1'b0);
        run_until_fs(300, 1'b0, n);
        check_int("s_period", n, 112);

        // Rejected loads: zero sync, total of 4096; 4095 still accepted
        bad = MODE_S;
        bad.hs = 12'd0;
        cyc(1'b1, 1'b1, bad);
        check_bit("err_pulse", d_err, 1'b1);
        check_bit("err_nopend", d_pend, 1'b0);
        cyc(1'b1, 1'b0, MODE_S);
        check_bit("err_clear", d_err, 1'b0);
        bad = MODE_S;
        bad.ha = 12'd4090;
        cyc(1'b1, 1'b1, bad);
        check_bit("err_ovf", d_err, 1'b1);
        bad.ha = 12'd4089;
        cyc(1'b1, 1'b1, bad);
        check_bit("max_ok", d_pend, 1'b1);

        // Latest load wins: S0 replaces the pending config
        cyc(1'b1, 1'b1, MODE_S0);
        run_until_fs(300, 1'b0, n);
        check_bit("s0_hsync_idle", d_hs, 1'b1);
        run_until_fs(300, 1'b0, n);
        check_int("s0_period", n, 112);

        // en toggling every other clock doubles the period
        run_until_fs(600, 1'b1, n);
        check_int("toggle_period", n, 224);

        // Load accepted while en is low
        cyc(1'b0, 1'b1, MODE_Z);
        check_bit("load_en0", d_pend, 1'b1);

        // Load in the boundary cycle is deferred to the next boundary
        k = 0;
        while (!(m_h == tot_h(m_cur) - 1 && m_v == tot_v(m_cur) - 1) && k < 400) begin
            cyc(1'b1, 1'b0, MODE_S0);
            k++;
        end
        cyc(1'b1, 1'b1, MODE_S);
        check_bit("bnd_fs", d_fs, 1'b1);
        check_bit("bnd_pend", d_pend, 1'b1);
        run_until_fs(300, 1'b0, n);
        check_int("z_period", n, 32);
        check_bit("bnd_applied", d_pend, 1'b0);

        // Asynchronous reset mid-line with a pending config
        cyc(1'b1, 1'b1, MODE_S0);
        repeat (3) cyc(1'b1, 1'b0, MODE_S0);
        @(posedge clk);
        #3;
        en    = 1'b0;
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_obs(), RST_OBS);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_until_fs(300, 1'b0, n);
        check_int("rst_restart", n, 1);
        run_until_fs(300, 1'b0, n);
        check_int("rst_period", n, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
